// File: rtl/if_stage_bp.sv
// Fetch stage: PC generation, 1-cycle SRAM fetch, predecode + 2-bit BHT prediction, skid of the fetched word.
// Address issued in cycle t returns on IF_to_ID_zip in t+1; when decode stalls the word is parked in inst_buf.
module if_stage_bp #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_allowin,
    input  logic        flush,
    input  logic [31:0] pc_real,
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [64:0] IF_to_ID_zip
);
    localparam logic [31:0] NOP   = 32'h03400000;
    localparam int          BHT_N = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t               state, state_nxt;
    logic [31:0]          fs_pc, fs_pc_nxt;
    logic [31:0]          inst_buf;
    logic                 buf_load;
    logic [1:0]           bht [BHT_N];

    logic [31:0]          cur_inst;
    logic [5:0]           op;
    logic                 is_b, is_bcc, predict;
    logic [31:0]          offs_b, offs_bcc, target, npc;
    logic [BHT_IDX_W-1:0] rd_idx, up_idx;
    logic                 unused_upd_pc_bits;

    // In RUN the SRAM is returning fs_pc's word; otherwise the parked copy is authoritative.
    assign cur_inst = (state == RUN) ? inst_sram_rdata : inst_buf;
    assign op       = cur_inst[31:26];
    assign is_b     = (op == 6'h14) || (op == 6'h15);
    assign is_bcc   = (op >= 6'h16) && (op <= 6'h1b);
    assign offs_b   = {{4{cur_inst[9]}}, cur_inst[9:0], cur_inst[25:10], 2'b00};
    assign offs_bcc = {{14{cur_inst[25]}}, cur_inst[25:10], 2'b00};
    assign rd_idx   = fs_pc[BHT_IDX_W+1:2];
    assign up_idx   = bht_upd_pc[BHT_IDX_W+1:2];
    assign unused_upd_pc_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

    always_comb begin
        predict = 1'b0;
        target  = fs_pc + offs_b;
        if (state != BOOT) begin
            if (is_b) begin
                predict = 1'b1;
            end else if (is_bcc) begin
                predict = bht[rd_idx][1];
                target  = fs_pc + offs_bcc;
            end
        end
    end

    assign npc          = predict ? target : fs_pc + 32'd4;
    assign IF_to_ID_zip = {predict, cur_inst, fs_pc};

    always_comb begin
        state_nxt      = state;
        fs_pc_nxt      = fs_pc;
        buf_load       = 1'b0;
        inst_sram_en   = 1'b0;
        inst_sram_addr = npc;
        case (state)
            BOOT: begin
                inst_sram_en   = 1'b1;
                inst_sram_addr = RESET_PC;
                if (ID_allowin) begin
                    fs_pc_nxt = RESET_PC;
                    state_nxt = RUN;
                end
            end
            RUN, HOLD: begin
                if (flush) begin
                    inst_sram_en   = 1'b1;
                    inst_sram_addr = pc_real;
                    fs_pc_nxt      = pc_real;
                    state_nxt      = RUN;
                end else if (ID_allowin) begin
                    inst_sram_en   = 1'b1;
                    inst_sram_addr = npc;
                    fs_pc_nxt      = npc;
                    state_nxt      = RUN;
                end else begin
                    buf_load  = (state == RUN);
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = BOOT;
        endcase
        // BOOT would otherwise request a fetch while reset is still held.
        if (!rst_n) inst_sram_en = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            fs_pc    <= RESET_PC - 32'd4;
            inst_buf <= NOP;
        end else begin
            state <= state_nxt;
            fs_pc <= fs_pc_nxt;
            if (buf_load) inst_buf <= inst_sram_rdata;
        end
    end

    // Same-cycle readers see the pre-update counter since the write lands on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (bht_upd_valid) begin
            if (bht_upd_taken) begin
                if (bht[up_idx] != 2'b11) bht[up_idx] <= bht[up_idx] + 2'b01;
            end else if (bht[up_idx] != 2'b00) begin
                bht[up_idx] <= bht[up_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_bp.sv
// Bench for if_stage_bp: stimulus task drives inputs and pushes the reference expectation,
// a negedge monitor pops and compares, and a behavioural SRAM serves a hashed program image.
module tb_if_stage_bp;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP      = 32'h03400000;
    localparam int          IDX_W    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ID_allowin = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_real = '0;
    logic        bht_upd_valid = 1'b0;
    logic [31:0] bht_upd_pc = '0;
    logic        bht_upd_taken = 1'b0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic [64:0] IF_to_ID_zip;

    if_stage_bp #(.RESET_PC(RESET_PC), .BHT_IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .ID_allowin(ID_allowin), .flush(flush), .pc_real(pc_real),
        .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .IF_to_ID_zip(IF_to_ID_zip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        en;
        logic [31:0] addr;
        logic [64:0] zip;
        bit          pc_v;
        logic [31:0] pc;
        bit          pred_v;
        logic        pred;
        bit          paddr_v;
        logic [31:0] paddr;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          done = 1'b0;
    bit          fin_chk = 1'b0;

    // Reference model state: program image, whether fetch has started, pc of the presented word, counters.
    logic [31:0] prog [logic [31:0]];
    bit          m_booted;
    logic [31:0] m_pc;
    int          m_bht [1 << IDX_W];
    bit          w_pc_v, w_pred_v, w_addr_v;
    logic [31:0] w_pc, w_addr;
    logic        w_pred;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [25:0] o26;
        logic [15:0] o16;
        logic [2:0]  k, r;
        if (prog.exists(a)) return prog[a];
        h   = (a * 32'h9E3779B1) ^ (a >> 11);
        k   = h[31:29];
        r   = h[27:25] % 3'd6;
        o26 = {{16{h[10]}}, h[10:1]};
        o16 = {{6{h[10]}}, h[10:1]};
        if (k < 3'd2) return {6'h14 + {5'b0, k[0]}, o26[15:0], o26[25:16]};
        if (k < 3'd5) return {6'h16 + {3'b0, r}, o16, h[9:0]};
        return {(h[28] ? 6'h13 : 6'h00), h[25:0]};
    endfunction

    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

    // Next fetch address implied by the word at pc: b/bl always taken, conditional branches follow the counter.
    function automatic void model_predict(input logic [31:0] inst, input logic [31:0] pc,
                                          output logic p, output logic [31:0] nxt);
        logic [5:0]  op;
        logic [25:0] o26;
        logic [15:0] o16;
        op  = inst[31:26];
        o26 = {inst[9:0], inst[25:10]};
        o16 = inst[25:10];
        p   = 1'b0;
        nxt = pc + 32'd4;
        if (op == 6'h14 || op == 6'h15) begin
            p   = 1'b1;
            nxt = pc + {{4{o26[25]}}, o26, 2'b00};
        end else if (op >= 6'h16 && op <= 6'h1b && m_bht[pc[IDX_W+1:2]] >= 2) begin
            p   = 1'b1;
            nxt = pc + {{14{o16[15]}}, o16, 2'b00};
        end
    endfunction

    task automatic want_pc(input logic [31:0] pc);
        w_pc_v = 1'b1; w_pc = pc;
    endtask
    task automatic want_pred(input logic p);
        w_pred_v = 1'b1; w_pred = p;
    endtask
    task automatic want_addr(input logic [31:0] a);
        w_addr_v = 1'b1; w_addr = a;
    endtask

    task automatic step(input bit rst, input bit alw, input bit fl, input logic [31:0] pr,
                        input bit uv, input logic [31:0] upc, input bit ut);
        exp_t        e;
        logic [31:0] inst, nxt;
        logic        p;
        int          ix;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !rst; ID_allowin = alw; flush = fl; pc_real = pr;
        bht_upd_valid = uv; bht_upd_pc = upc; bht_upd_taken = ut;
        e = '{cyc: cyc, en: 1'b0, addr: '0, zip: {1'b0, NOP, RESET_PC - 32'd4},
              pc_v: w_pc_v, pc: w_pc, pred_v: w_pred_v, pred: w_pred, paddr_v: w_addr_v, paddr: w_addr};
        if (rst) begin
            m_booted = 1'b0;
            for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = 1;
        end else begin
            if (!m_booted) begin
                e.en = 1'b1; e.addr = RESET_PC;
                if (alw) begin m_booted = 1'b1; m_pc = RESET_PC; end
            end else begin
                inst = mem_word(m_pc);
                model_predict(inst, m_pc, p, nxt);
                e.zip = {p, inst, m_pc};
                if (fl) begin
                    e.en = 1'b1; e.addr = pr; m_pc = pr;
                end else if (alw) begin
                    e.en = 1'b1; e.addr = nxt; m_pc = nxt;
                end
            end
            if (uv) begin
                ix = int'(upc[IDX_W+1:2]);
                if (ut) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
                else    m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
            end
        end
        sb.push_back(e);
        w_pc_v = 1'b0; w_pred_v = 1'b0; w_addr_v = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty at negedge: got none, required an expectation");
            end else begin
                me = sb.pop_front();
                checks++;
                if (inst_sram_en !== me.en) begin
                    errors++;
                    $display("FAIL en cyc=%0d got=%b required=%b", me.cyc, inst_sram_en, me.en);
                end
                if (me.en) begin
                    checks++;
                    if (inst_sram_addr !== me.addr) begin
                        errors++;
                        $display("FAIL addr cyc=%0d got=%h required=%h", me.cyc, inst_sram_addr, me.addr);
                    end
                end
                checks++;
                if (IF_to_ID_zip !== me.zip) begin
                    errors++;
                    $display("FAIL zip cyc=%0d got=%h required=%h", me.cyc, IF_to_ID_zip, me.zip);
                end
                if (me.pc_v) begin
                    checks++;
                    if (IF_to_ID_zip[31:0] !== me.pc) begin
                        errors++;
                        $display("FAIL dir_pc cyc=%0d got=%h required=%h", me.cyc, IF_to_ID_zip[31:0], me.pc);
                    end
                end
                if (me.pred_v) begin
                    checks++;
                    if (IF_to_ID_zip[64] !== me.pred) begin
                        errors++;
                        $display("FAIL dir_pred cyc=%0d got=%b required=%b", me.cyc, IF_to_ID_zip[64], me.pred);
                    end
                end
                if (me.paddr_v) begin
                    checks++;
                    if (inst_sram_addr !== me.paddr || inst_sram_en !== 1'b1) begin
                        errors++;
                        $display("FAIL dir_addr cyc=%0d got=%b/%h required=1/%h",
                                 me.cyc, inst_sram_en, inst_sram_addr, me.paddr);
                    end
                end
            end
        end else if (done && !fin_chk) begin
            fin_chk = 1'b1;
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL sb_leftover got=%0d entries required=0", sb.size());
            end
        end
    end

    initial begin
        bit          alw, fl, uv, ut, rs;
        logic [31:0] pr, upc;
        w_pc_v = 1'b0; w_pred_v = 1'b0; w_addr_v = 1'b0;
        w_pc = '0; w_pred = 1'b0; w_addr = '0;
        m_booted = 1'b0; m_pc = '0;
        for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = 1;
        for (int i = 0; i < 64; i++) prog[RESET_PC + 32'(i * 4)] = NOP;
        prog[32'h1c000008] = 32'h02800421;
        prog[32'h1c000010] = 32'h50001000;   // b +16
        prog[32'h1c000040] = 32'h58002000;   // beq +32

        repeat (3) step(1, 0, 0, '0, 0, '0, 0);
        want_pc(RESET_PC - 32'd4); want_pred(1'b0); want_addr(32'h1c000000);
        step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c000000); want_addr(32'h1c000004); step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c000004); want_addr(32'h1c000008); step(0, 1, 0, '0, 0, '0, 0);
        repeat (3) begin
            want_pc(32'h1c000008); step(0, 0, 0, '0, 0, '0, 0);
        end
        want_pc(32'h1c000008); want_addr(32'h1c00000c); step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c00000c); want_addr(32'h1c000010); step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c000010); want_pred(1'b1); want_addr(32'h1c000020); step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c000020); want_addr(32'h1c000024); step(0, 1, 0, '0, 0, '0, 0);
        for (int i = 0; i < 40 && m_pc != 32'h1c000040; i++) step(0, 1, 0, '0, 0, '0, 0);
        want_pc(32'h1c000040); want_pred(1'b0); want_addr(32'h1c000044); step(0, 1, 0, '0, 0, '0, 0);
        repeat (2) step(0, 1, 0, '0, 1, 32'h1c000040, 1);
        want_addr(32'h1c000040); step(0, 1, 1, 32'h1c000040, 0, '0, 0);
        want_pc(32'h1c000040); want_pred(1'b1); want_addr(32'h1c000060); step(0, 1, 0, '0, 0, '0, 0);
        repeat (2) step(0, 0, 0, '0, 0, '0, 0);
        want_addr(32'h1c000100); step(0, 0, 1, 32'h1c000100, 0, '0, 0);
        want_pc(32'h1c000100); step(0, 1, 0, '0, 0, '0, 0);
        // Saturation at 11, then two not-taken updates observed across consecutive refetches.
        want_addr(32'h1c000040); step(0, 1, 1, 32'h1c000040, 1, 32'h1c000040, 1);
        want_pc(32'h1c000040); want_pred(1'b1); step(0, 1, 1, 32'h1c000040, 1, 32'h1c000040, 0);
        want_pc(32'h1c000040); want_pred(1'b1); step(0, 1, 1, 32'h1c000040, 1, 32'h1c000040, 0);
        want_pc(32'h1c000040); want_pred(1'b0); want_addr(32'h1c000044); step(0, 1, 0, '0, 0, '0, 0);
        repeat (2) step(0, 0, 0, '0, 0, '0, 0);
        repeat (2) step(1, 0, 0, '0, 0, '0, 0);
        want_pc(RESET_PC - 32'd4); want_addr(RESET_PC); step(0, 1, 0, '0, 0, '0, 0);

        for (int n = 0; n < 3000; n++) begin
            rs  = ($urandom_range(0, 499) == 0);
            alw = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) pr = 32'hfffffff0 + ($urandom_range(0, 3) << 2);
            else                           pr = RESET_PC + ($urandom_range(0, 4095) << 2);
            uv  = ($urandom_range(0, 2) == 0);
            ut  = $urandom_range(0, 1) == 1;
            upc = ($urandom_range(0, 1) == 1) ? m_pc : ($urandom & 32'hfffffffc);
            step(rs, alw, fl, pr, uv, upc, ut);
        end

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        done   = 1'b1;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
